// File: rtl/comp.sv
`default_nettype none
// ============================================================================
//  Module      : comp
//  Description : Registered WIDTH-bit unsigned magnitude comparator with
//                74HC85-style cascade inputs. When A == B the cascade inputs
//                from a lower slice decide the result, so several stages can
//                be chained from the LSB slice up to the MSB slice.
//                Outputs are registered, giving one cycle of latency.
//  Revision    : 1.0  initial release
// ============================================================================
module comp #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             IGT,
    input  logic             ILE,
    input  logic             IEQ,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             FGT,
    output logic             FLE,
    output logic             FEQ,
    output logic             out_valid
);

    // Ripple compare chain, built from the LSB upward. Entry i+1 holds the
    // verdict for bits [i:0]. A higher bit that differs overrides whatever
    // the lower bits decided, which gives the MSB priority of a plain
    // unsigned compare.
    logic [WIDTH:0]   w_gt_chain;
    logic [WIDTH:0]   w_lt_chain;
    logic [WIDTH-1:0] w_bit_eq;

    assign w_gt_chain[0] = 1'b0;
    assign w_lt_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_cmp
            assign w_bit_eq[gi]      = ~(A[gi] ^ B[gi]);
            assign w_gt_chain[gi+1]  = (A[gi] & ~B[gi]) | (w_bit_eq[gi] & w_gt_chain[gi]);
            assign w_lt_chain[gi+1]  = (~A[gi] & B[gi]) | (w_bit_eq[gi] & w_lt_chain[gi]);
        end
    endgenerate

    logic w_a_gt_b;
    logic w_a_lt_b;
    logic w_a_eq_b;

    assign w_a_gt_b = w_gt_chain[WIDTH];
    assign w_a_lt_b = w_lt_chain[WIDTH];
    assign w_a_eq_b = &w_bit_eq;

    // Combine the local compare with the cascade inputs. A local difference
    // wins outright; on equality IEQ dominates, otherwise IGT/ILE pass
    // through unchanged (including the degenerate 1,1 and 0,0 patterns).
    logic w_gt;
    logic w_lt;
    logic w_eq;

    always_comb begin
        w_gt = 1'b0;
        w_lt = 1'b0;
        w_eq = 1'b0;
        if (w_a_gt_b) begin
            w_gt = 1'b1;
        end else if (w_a_lt_b) begin
            w_lt = 1'b1;
        end else if (w_a_eq_b && IEQ) begin
            w_eq = 1'b1;
        end else begin
            w_gt = IGT;
            w_lt = ILE;
        end
    end

    // Output registers: flags load only on valid input and hold otherwise;
    // out_valid tracks in_valid. Reset clears everything, discarding any
    // in-flight result.
    logic r_fgt;
    logic r_fle;
    logic r_feq;
    logic r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fgt       <= 1'b0;
            r_fle       <= 1'b0;
            r_feq       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_fgt <= w_gt;
                r_fle <= w_lt;
                r_feq <= w_eq;
            end
        end
    end

    assign FGT       = r_fgt;
    assign FLE       = r_fle;
    assign FEQ       = r_feq;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_comp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp
//  Description : Self-checking bench for comp (WIDTH=4). Directed cases,
//                an exhaustive A/B/cascade sweep and a randomized stream are
//                checked against a behavioural model of the comparator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_comp;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             IGT;
    logic             ILE;
    logic             IEQ;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             FGT;
    logic             FLE;
    logic             FEQ;
    logic             out_valid;

    int nvec;
    int nerr;

    // Model state: what the outputs should show after the next edge.
    logic [2:0] m_flags;
    logic       m_ov;

    comp #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .IGT       (IGT),
        .ILE       (ILE),
        .IEQ       (IEQ),
        .A         (A),
        .B         (B),
        .FGT       (FGT),
        .FLE       (FLE),
        .FEQ       (FEQ),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator rules expressed on plain integers: {gt, lt, eq}.
    function automatic logic [2:0] ref_cmp(input int a, input int b,
                                           input logic igt, input logic ile,
                                           input logic ieq);
        if (a > b)       return 3'b100;
        else if (a < b)  return 3'b010;
        else if (ieq)    return 3'b001;
        else             return {igt, ile, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed={FGT,FLE,FEQ,ov}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, step the model, and check 1 ns after the edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input int a, input int b,
                        input logic igt, input logic ile, input logic ieq);
        rst      = r;
        in_valid = v;
        A        = a[WIDTH-1:0];
        B        = b[WIDTH-1:0];
        IGT      = igt;
        ILE      = ile;
        IEQ      = ieq;
        @(posedge clk);
        #1;
        if (r) begin
            m_flags = 3'b000;
            m_ov    = 1'b0;
        end else begin
            m_ov = v;
            if (v) m_flags = ref_cmp(a, b, igt, ile, ieq);
        end
        check(tag, {FGT, FLE, FEQ, out_valid}, {m_flags, m_ov});
    endtask

    initial begin
        nvec     = 0;
        nerr     = 0;
        m_flags  = 3'b000;
        m_ov     = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b1;
        A        = '0;
        B        = '0;
        IGT      = 1'b0;
        ILE      = 1'b0;
        IEQ      = 1'b1;

        // Reset, with in_valid high to show rst dominates
        step("reset0", 1'b1, 1'b1, 11, 4, 1'b0, 1'b0, 1'b1);
        step("reset1", 1'b1, 1'b1, 3, 3, 1'b0, 1'b0, 1'b1);

        // Directed magnitude cases
        step("case1_11gt4",  1'b0, 1'b1, 11, 4,  1'b0, 1'b0, 1'b1);
        step("case2_8lt12",  1'b0, 1'b1, 8,  12, 1'b0, 1'b0, 1'b1);
        step("case3_2gt1",   1'b0, 1'b1, 2,  1,  1'b0, 1'b0, 1'b1);
        step("case4_14lt15", 1'b0, 1'b1, 14, 15, 1'b0, 1'b0, 1'b1);

        // Equal operands: cascade sweep
        step("case5_igt",    1'b0, 1'b1, 11, 11, 1'b1, 1'b0, 1'b0);
        step("case5_ile",    1'b0, 1'b1, 11, 11, 1'b0, 1'b1, 1'b0);
        step("case5_ieq",    1'b0, 1'b1, 11, 11, 1'b0, 1'b0, 1'b1);
        step("case5_all1",   1'b0, 1'b1, 11, 11, 1'b1, 1'b1, 1'b1);
        step("case5_all0",   1'b0, 1'b1, 11, 11, 1'b0, 1'b0, 1'b0);
        step("case5_gtle",   1'b0, 1'b1, 11, 11, 1'b1, 1'b1, 1'b0);

        // Cascade ignored when operands differ
        step("case6_0lt15",  1'b0, 1'b1, 0,  15, 1'b1, 1'b0, 1'b1);
        step("case6_15gt0",  1'b0, 1'b1, 15, 0,  1'b0, 1'b1, 1'b0);

        // Hold: flags keep the last valid result while operands change
        step("case7_load",   1'b0, 1'b1, 9,  3,  1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("case7_hold", 1'b0, 1'b0, 1, 14, 1'b0, 1'b1, 1'b0);

        // Reset mid-stream discards the in-flight result
        step("case8_pre",    1'b0, 1'b1, 5,  5,  1'b0, 1'b0, 1'b1);
        step("case8_rst",    1'b1, 1'b1, 12, 2,  1'b0, 1'b0, 1'b1);
        step("case8_post",   1'b0, 1'b1, 2,  12, 1'b0, 1'b0, 1'b1);

        // Exhaustive sweep: every A/B pair with every cascade combination
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 8; c++)
                    step("case9_sweep", 1'b0, 1'b1, a, b, c[2], c[1], c[0]);

        // Randomized stream with sporadic invalid cycles and resets
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic v;
            r = ($urandom_range(0, 31) == 0);
            v = ($urandom_range(0, 3) != 0);
            step("random", r, v,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
